// File: rtl/j1_io_pkg.sv
// Shared definitions for the j1 I/O peripherals: bus addresses, status bit
// positions and the UART serializer state encoding.
package j1_io_pkg;

  localparam logic [15:0] IO_DATA_ADDR = 16'h1000;
  localparam logic [15:0] IO_STAT_ADDR = 16'h2000;

  localparam int STAT_READY_BIT = 0;
  localparam int STAT_IDLE_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with first-word-fall-through read data. Pointers carry an
// extra wrap bit so full and empty are distinguishable without a counter.
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/io_uart_tx.sv
// I/O-mapped 8N1 UART transmitter: CPU pushes bytes into a TX FIFO and polls
// a status word; a baud-timed serializer drains the FIFO onto uart_tx.
module io_uart_tx
  import j1_io_pkg::*;
#(
  parameter int          BAUD_DIV   = 104,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DATA_ADDR  = IO_DATA_ADDR,
  parameter logic [15:0] STAT_ADDR  = IO_STAT_ADDR
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_wr,
  input  logic        io_rd,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  output logic        uart_tx,
  output logic        busy
);

  localparam int            CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q, tx_d;
  logic          ovf_q;
  logic [15:0]   din_q;

  logic          wr_data, rd_stat;
  logic          fifo_full, fifo_empty, pop;
  logic [7:0]    fifo_dout;
  logic          bit_end, idle;
  logic [15:0]   status;
  logic          unused_dout_hi;

  assign wr_data        = io_wr && (io_addr == DATA_ADDR);
  assign rd_stat        = io_rd && (io_addr == STAT_ADDR);
  assign bit_end        = (baud_q == '0);
  assign idle           = fifo_empty && (state_q == TX_IDLE);
  assign unused_dout_hi = ^io_dout[15:8];

  io_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetq  (resetq),
    .push_i  (wr_data),
    .data_i  (io_dout[7:0]),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) state_q <= TX_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TX_IDLE:  if (!fifo_empty) state_d = TX_START;
      TX_START: if (bit_end) state_d = TX_DATA;
      TX_DATA:  if (bit_end && (bit_q == 3'd7)) state_d = TX_STOP;
      TX_STOP:  if (bit_end) state_d = fifo_empty ? TX_IDLE : TX_START;
      default:  state_d = TX_IDLE;
    endcase
  end

  // A pop at the end of STOP chains the next frame with no idle gap.
  always_comb begin
    tx_d = 1'b1;
    pop  = 1'b0;
    unique case (state_q)
      TX_IDLE:  pop  = !fifo_empty;
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shift_q[0];
      TX_STOP:  pop  = bit_end && !fifo_empty;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      baud_q  <= BAUD_LAST;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      tx_q   <= tx_d;
      baud_q <= ((state_q == TX_IDLE) || bit_end) ? BAUD_LAST : baud_q - BAUD_ONE;
      if (state_q != TX_DATA) bit_q <= '0;
      else if (bit_end)       bit_q <= bit_q + 3'd1;
      if (pop)                               shift_q <= fifo_dout;
      else if ((state_q == TX_DATA) && bit_end) shift_q <= {1'b0, shift_q[7:1]};
    end
  end

  always_comb begin
    status                 = '0;
    status[STAT_READY_BIT] = !fifo_full;
    status[STAT_IDLE_BIT]  = idle;
    status[STAT_OVF_BIT]   = ovf_q;
  end

  // A dropped write in the same cycle as a status read keeps OVERFLOW set.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      ovf_q <= 1'b0;
      din_q <= '0;
    end else begin
      if (wr_data && fifo_full) ovf_q <= 1'b1;
      else if (rd_stat)         ovf_q <= 1'b0;
      din_q <= rd_stat ? status : 16'h0000;
    end
  end

  assign io_din  = din_q;
  assign uart_tx = tx_q;
  assign busy    = !idle;

endmodule

// File: tb/tb_io_uart_tx.sv
// Self-checking bench for io_uart_tx: directed frames, overflow, bad
// addresses, mid-frame reset and randomized bursts against a line model.
module tb_io_uart_tx;

  localparam int BAUD  = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * BAUD;
  localparam logic [15:0] DATA = 16'h1000;
  localparam logic [15:0] STAT = 16'h2000;

  logic        clk = 1'b0;
  logic        resetq;
  logic        io_wr, io_rd;
  logic [15:0] io_addr, io_dout;
  logic [15:0] io_din;
  logic        uart_tx, busy;

  int          cyc = 0;
  int          assertCount = 0;
  int          failCount = 0;
  logic [7:0]  expQ[$];

  io_uart_tx #(
    .BAUD_DIV   (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .resetq  (resetq),
    .io_wr   (io_wr),
    .io_rd   (io_rd),
    .io_addr (io_addr),
    .io_dout (io_dout),
    .io_din  (io_din),
    .uart_tx (uart_tx),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the write edge (cyc = that edge).
  task automatic applyWrite(input logic [15:0] addr, input logic [15:0] data);
    io_wr = 1'b1; io_addr = addr; io_dout = data;
    @(negedge clk);
    io_wr = 1'b0;
  endtask

  task automatic applyRead(input logic [15:0] addr, output logic [15:0] data);
    io_rd = 1'b1; io_addr = addr;
    @(negedge clk);
    io_rd = 1'b0;
    data = io_din;
  endtask

  // Line model: frames of {start, 8 data LSB-first, stop}, each bit BAUD cycles,
  // first start bit visible after edge firstEdge+2, frames back-to-back.
  task automatic expectFrames(input int firstEdge, input int nFrames);
    int endEdge, t, idx;
    logic expTx;
    endEdge = firstEdge + 1 + FRAME * nFrames;
    while (cyc <= endEdge) begin
      if (cyc >= firstEdge + 2) begin
        t   = cyc - (firstEdge + 2);
        idx = (t % FRAME) / BAUD;
        if (idx == 0)      expTx = 1'b0;
        else if (idx == 9) expTx = 1'b1;
        else               expTx = expQ[t / FRAME][idx - 1];
        checkOutput($sformatf("tx t=%0d", t), {15'b0, uart_tx}, {15'b0, expTx});
        checkOutput($sformatf("busy t=%0d", t), {15'b0, busy}, {15'b0, cyc != endEdge});
      end
      if (cyc == endEdge) break;
      @(negedge clk);
    end
  endtask

  // k consecutive random writes from idle: one byte goes straight to the
  // shifter, DEPTH more fit in the FIFO, the rest are dropped.
  task automatic burstTest(input int k, input bit extraRead);
    int first, held;
    logic [7:0]  b;
    logic [15:0] d, expStat;
    expQ.delete();
    for (int i = 0; i < k; i++) begin
      b = 8'($urandom);
      if (i < DEPTH + 1) expQ.push_back(b);
      applyWrite(DATA, {8'($urandom), b});
      if (i == 0) first = cyc;
    end
    held = (k == 1) ? 1 : ((k < DEPTH + 1) ? k : DEPTH + 1) - 1;
    expStat = {13'b0, k > DEPTH + 1, 1'b0, held < DEPTH};
    applyRead(STAT, d);
    checkOutput($sformatf("burst%0d stat", k), d, expStat);
    if (extraRead) begin
      applyRead(STAT, d);
      checkOutput("burst stat after clear", d, {13'b0, 1'b0, 1'b0, held < DEPTH});
    end
    expectFrames(first, expQ.size());
    applyRead(STAT, d);
    checkOutput($sformatf("burst%0d stat idle", k), d, 16'h0003);
  endtask

  initial begin
    logic [15:0] d;
    logic [7:0]  b0;
    int          n;

    resetq = 1'b0; io_wr = 1'b0; io_rd = 1'b0; io_addr = '0; io_dout = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset tx", {15'b0, uart_tx}, 16'h0001);
    checkOutput("reset busy", {15'b0, busy}, 16'h0000);
    checkOutput("reset din", io_din, 16'h0000);
    resetq = 1'b1;
    @(negedge clk);

    applyRead(STAT, d);
    checkOutput("stat after reset", d, 16'h0003);
    @(negedge clk);
    checkOutput("din returns to 0", io_din, 16'h0000);
    checkOutput("idle tx", {15'b0, uart_tx}, 16'h0001);

    // Single frame 0x55 with exact latency and return to IDLE.
    applyWrite(DATA, 16'h1255);
    n = cyc;
    expQ = '{8'h55};
    expectFrames(n, 1);
    applyRead(STAT, d);
    checkOutput("stat after 0x55", d, 16'h0003);

    // Two frames back-to-back with no gap.
    applyWrite(DATA, 16'h00A5);
    n = cyc;
    applyWrite(DATA, 16'h003C);
    expQ = '{8'hA5, 8'h3C};
    expectFrames(n, 2);

    // Overflow: six writes, sixth dropped; OVERFLOW clears on read.
    burstTest(6, 1'b1);

    // Writes and reads to neighbouring addresses are ignored.
    applyWrite(16'h1001, 16'h00AB);
    applyRead(16'h2001, d);
    checkOutput("bad addr din", d, 16'h0000);
    for (int i = 0; i < 12; i++) begin
      checkOutput("bad addr tx", {15'b0, uart_tx}, 16'h0001);
      @(negedge clk);
    end
    applyRead(STAT, d);
    checkOutput("bad addr stat", d, 16'h0003);

    // Reset during data bit 3 (bit 3 forced low so the release to 1 is visible).
    b0 = 8'($urandom) & 8'hF7;
    applyWrite(DATA, {8'h00, b0});
    n = cyc;
    applyWrite(DATA, 16'h00FF);
    while (cyc < n + 2 + 4 * BAUD + 1) @(negedge clk);
    checkOutput("tx in bit3", {15'b0, uart_tx}, 16'h0000);
    resetq = 1'b0;
    #1;
    checkOutput("tx on reset", {15'b0, uart_tx}, 16'h0001);
    checkOutput("busy on reset", {15'b0, busy}, 16'h0000);
    @(negedge clk);
    resetq = 1'b1;
    @(negedge clk);
    applyRead(STAT, d);
    checkOutput("stat after mid reset", d, 16'h0003);
    for (int i = 0; i < 2 * FRAME; i++) begin
      checkOutput("no residual frame", {15'b0, uart_tx}, 16'h0001);
      @(negedge clk);
    end

    // Randomized bursts, with and without overflow.
    for (int r = 0; r < 5; r++) burstTest($urandom_range(1, DEPTH + 3), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
